// File: rtl/seg_pkg.sv
// Segment encodings and helpers shared by the seven-segment scanner.
// Bit order is seg[6]=a .. seg[0]=g, active-high.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h01;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // ceil(w*log10(2)) + 1 decimal digits; the spare digit makes overflow visible.
    function automatic int bcd_digits(input int w);
        return (w * 30103 + 99999) / 100000 + 1;
    endfunction

endpackage

// File: rtl/seg_scan_display_bin2bcd.sv
// Sequential double-dabble converter: one correct-and-shift step per clock.
// done_o pulses on the last busy cycle, with bcd_o carrying the final result.
module bin2bcd_seq #(
    parameter int VAL_W      = 10,
    parameter int BCD_DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [VAL_W-1:0]        bin_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [4*BCD_DIGITS-1:0] bcd_o
);

    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0]        bin_q, bin_d;
    logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    last;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        assign bcd_adj[4*g +: 4] = (bcd_q[4*g +: 4] >= 4'd5) ? bcd_q[4*g +: 4] + 4'd3
                                                             : bcd_q[4*g +: 4];
    end

    assign last = busy_q && (cnt_q == CNT_W'(VAL_W - 1));

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (busy_q) begin
            bcd_d = (4*BCD_DIGITS)'({bcd_adj, bin_q[VAL_W-1]});
            bin_d = bin_q << 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
                busy_d = 1'b0;
            end
        end else if (start_i) begin
            bin_d  = bin_i;
            bcd_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = last;
    assign bcd_o  = bcd_d;

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner for the water-level panel: value in tenths
// with leading-zero blanking, overflow dashes, an auxiliary pump-speed digit and alarm blink.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int VAL_W      = 10,
    parameter int VAL_DIGITS = 4,
    parameter int DP_POS     = 1,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VAL_W-1:0]      value_in,
    input  logic                  value_load,
    input  logic [3:0]            aux_digit,
    input  logic                  aux_en,
    input  logic                  blink_en,
    output logic                  busy,
    output logic [6:0]            seg,
    output logic                  seg_dot,
    output logic [NUM_DIGITS-1:0] cat
);

    localparam int BCD_DIGITS = bcd_digits(VAL_W);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W      = $clog2(SCAN_DIV);
    localparam int BLK_W      = $clog2(BLINK_DIV);

    logic                    conv_done;
    logic [4*BCD_DIGITS-1:0] conv_bcd;
    logic [BCD_DIGITS-1:0]   ovf_bits;

    logic [4*BCD_DIGITS-1:0] disp_q, disp_d;
    logic                    ovf_q, ovf_d;
    logic [PRE_W-1:0]        pre_q, pre_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BLK_W-1:0]        bcnt_q, bcnt_d;
    logic                    phase_q, phase_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dot_q, dot_d;
    logic [NUM_DIGITS-1:0]   cat_q, cat_d;

    logic [4*(NUM_DIGITS+BCD_DIGITS)-1:0] disp_pad;
    logic [3:0]              dig [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lz;

    bin2bcd_seq #(
        .VAL_W      (VAL_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (value_load),
        .bin_i   (value_in),
        .busy_o  (busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    // Any nonzero digit above the visible ones means the value does not fit.
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_ovf
        if (g >= VAL_DIGITS) begin : g_hi
            assign ovf_bits[g] = |conv_bcd[4*g +: 4];
        end else begin : g_lo
            assign ovf_bits[g] = 1'b0;
        end
    end

    assign disp_pad = {{(4*NUM_DIGITS){1'b0}}, disp_q};

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        assign dig[g] = disp_pad[4*g +: 4];
    end

    // lz[p]: digit p and every higher value digit are zero.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            lz[i] = 1'b1;
            for (int j = i; j < VAL_DIGITS; j++) begin
                if (dig[j] != 4'd0) begin
                    lz[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        pre_d   = pre_q + PRE_W'(1);
        idx_d   = idx_q;
        bcnt_d  = bcnt_q + BLK_W'(1);
        phase_d = phase_q;

        if (conv_done) begin
            disp_d = conv_bcd;
            ovf_d  = |ovf_bits;
        end

        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (int'(idx_q) == NUM_DIGITS - 1) ? '0 : idx_q + IDX_W'(1);
        end

        if (!blink_en) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (bcnt_q == BLK_W'(BLINK_DIV - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end
    end

    always_comb begin
        seg_d = SEG_BLANK;
        dot_d = 1'b0;
        cat_d = ~(NUM_DIGITS'(1) << idx_q);
        if (int'(idx_q) < VAL_DIGITS) begin
            if (ovf_q) begin
                seg_d = SEG_DASH;
            end else begin
                if (!(int'(idx_q) > DP_POS && lz[idx_q])) begin
                    seg_d = bcd_to_seg(dig[idx_q]);
                end
                dot_d = (int'(idx_q) == DP_POS);
            end
        end else if (int'(idx_q) == NUM_DIGITS - 1) begin
            if (aux_en) begin
                seg_d = bcd_to_seg(aux_digit);
            end
        end
        if (phase_q) begin
            seg_d = SEG_BLANK;
            dot_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            pre_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            seg_q   <= SEG_BLANK;
            dot_q   <= 1'b0;
            cat_q   <= '1;
        end else begin
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            dot_q   <= dot_d;
            cat_q   <= cat_d;
        end
    end

    assign seg     = seg_q;
    assign seg_dot = dot_q;
    assign cat     = cat_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: two instances (4 and 3 value digits) share stimulus and
// are compared each cycle against a decimal-arithmetic model of the panel.
module tb_seg_scan_display;

    localparam int N  = 8;
    localparam int VW = 10;
    localparam int DP = 1;
    localparam int SD = 4;
    localparam int BD = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [VW-1:0] value_in = '0;
    logic          value_load = 1'b0;
    logic [3:0]    aux_digit = 4'd0;
    logic          aux_en = 1'b0;
    logic          blink_en = 1'b0;

    logic          busy4, dot4, busy3, dot3;
    logic [6:0]    seg4, seg3;
    logic [N-1:0]  cat4, cat3;

    int total = 0;
    int bad   = 0;
    int mval  = 0;
    int n, bn, bn_prev;

    always #5 clk = ~clk;

    seg_scan_display #(.NUM_DIGITS(N), .VAL_W(VW), .VAL_DIGITS(4), .DP_POS(DP),
                       .SCAN_DIV(SD), .BLINK_DIV(BD)) dut4 (
        .clk(clk), .rst(rst), .value_in(value_in), .value_load(value_load),
        .aux_digit(aux_digit), .aux_en(aux_en), .blink_en(blink_en),
        .busy(busy4), .seg(seg4), .seg_dot(dot4), .cat(cat4));

    seg_scan_display #(.NUM_DIGITS(N), .VAL_W(VW), .VAL_DIGITS(3), .DP_POS(DP),
                       .SCAN_DIV(SD), .BLINK_DIV(BD)) dut3 (
        .clk(clk), .rst(rst), .value_in(value_in), .value_load(value_load),
        .aux_digit(aux_digit), .aux_en(aux_en), .blink_en(blink_en),
        .busy(busy3), .seg(seg3), .seg_dot(dot3), .cat(cat3));

    // Clock edges since reset release, and consecutive edges with blink requested.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            n       <= 0;
            bn      <= 0;
            bn_prev <= 0;
        end else begin
            n       <= n + 1;
            bn_prev <= bn;
            bn      <= blink_en ? bn + 1 : 0;
        end
    end

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    // Expected {cat, seg_dot, seg} for an instance showing vd value digits.
    function automatic logic [15:0] exp_out(input int vd);
        int         idx;
        logic [6:0] s;
        logic       d;
        logic [7:0] c;
        idx = ((n - 1) / SD) % N;
        s = 7'b0;
        d = 1'b0;
        if (idx < vd) begin
            if (mval > pow10(vd) - 1) begin
                s = 7'b0000001;
            end else begin
                if (!(idx > DP && mval < pow10(idx))) s = glyph((mval / pow10(idx)) % 10);
                d = (idx == DP);
            end
        end else if (idx == N - 1 && aux_en && aux_digit <= 4'd9) begin
            s = glyph(int'(aux_digit));
        end
        if (((bn_prev / BD) % 2) == 1) begin
            s = 7'b0;
            d = 1'b0;
        end
        c = ~(8'd1 << idx);
        return {c, d, s};
    endfunction

    task automatic watch(input int cycles, input string tag);
        logic [15:0] e4, e3;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            e4 = exp_out(4);
            e3 = exp_out(3);
            total++;
            if ({cat4, dot4, seg4} !== e4) begin
                bad++;
                $display("FAIL %s_d4 t=%0t got=%h exp=%h", tag, $time, {cat4, dot4, seg4}, e4);
            end
            total++;
            if ({cat3, dot3, seg3} !== e3) begin
                bad++;
                $display("FAIL %s_d3 t=%0t got=%h exp=%h", tag, $time, {cat3, dot3, seg3}, e3);
            end
            total++;
            if ({busy4, busy3} !== 2'b00) begin
                bad++;
                $display("FAIL %s_idle_busy t=%0t got=%b exp=00", tag, $time, {busy4, busy3});
            end
        end
    endtask

    // Called at a negedge. A second load strobe is raised after glitch_at busy cycles (0 = none).
    task automatic convert(input int v, input int glitch_at, input int gv, input string tag);
        int          bc;
        logic [15:0] e4, e3;
        value_in   = VW'(v);
        value_load = 1'b1;
        @(negedge clk);
        value_load = 1'b0;
        bc = 0;
        while (busy4 === 1'b1 && bc < 20) begin
            e4 = exp_out(4);
            e3 = exp_out(3);
            total++;
            if ({cat4, dot4, seg4, busy3} !== {e4, 1'b1}) begin
                bad++;
                $display("FAIL %s_hold4 t=%0t got=%h exp=%h", tag, $time, {cat4, dot4, seg4, busy3}, {e4, 1'b1});
            end
            total++;
            if ({cat3, dot3, seg3} !== e3) begin
                bad++;
                $display("FAIL %s_hold3 t=%0t got=%h exp=%h", tag, $time, {cat3, dot3, seg3}, e3);
            end
            bc++;
            if (bc == glitch_at) begin
                value_in   = VW'(gv);
                value_load = 1'b1;
            end
            @(negedge clk);
            value_load = 1'b0;
        end
        total++;
        if (bc != VW) begin
            bad++;
            $display("FAIL %s_busy_len got=%0d exp=%0d", tag, bc, VW);
        end
        e4 = exp_out(4);
        total++;
        if ({cat4, dot4, seg4, busy3} !== {e4, 1'b0}) begin
            bad++;
            $display("FAIL %s_fall t=%0t got=%h exp=%h", tag, $time, {cat4, dot4, seg4, busy3}, {e4, 1'b0});
        end
        mval = v;
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) watch(37, "pre_rst");
            if (k == 2) begin
                value_in   = VW'(125);
                value_load = 1'b1;
                @(negedge clk);
                value_load = 1'b0;
                repeat (4) @(negedge clk);
                total++;
                if (busy4 !== 1'b1) begin
                    bad++;
                    $display("FAIL rst_conv_started got=%b exp=1", busy4);
                end
            end
            #2 rst = 1'b0;
            #1;
            total++;
            if ({cat4, seg4, dot4, busy4} !== {8'hFF, 7'h00, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL rst%0d_d4 got=%h exp=%h", k, {cat4, seg4, dot4, busy4}, {8'hFF, 9'h000});
            end
            total++;
            if ({cat3, seg3, dot3, busy3} !== {8'hFF, 7'h00, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL rst%0d_d3 got=%h exp=%h", k, {cat3, seg3, dot3, busy3}, {8'hFF, 9'h000});
            end
            @(negedge clk);
            rst  = 1'b1;
            mval = 0;
            watch(70, "post_rst");
        end
    endtask

    task automatic test_load_125;
        convert(125, 0, 0, "v125");
        watch(70, "v125");
    endtask

    task automatic test_load_7;
        convert(7, 4, 999, "v7");
        watch(70, "v7");
        convert(0, 10, 999, "v0_edge");
        watch(40, "v0");
    endtask

    task automatic test_overflow;
        convert(1023, 0, 0, "v1023");
        watch(70, "v1023");
        convert(45, 0, 0, "v45");
        watch(70, "v45");
        convert(999, 0, 0, "v999");
        watch(40, "v999");
        convert(1000, 0, 0, "v1000");
        watch(40, "v1000");
    endtask

    task automatic test_aux;
        aux_en    = 1'b1;
        aux_digit = 4'd2;
        watch(70, "aux2");
        aux_digit = 4'd12;
        watch(40, "aux12");
        aux_digit = 4'd9;
        watch(40, "aux9");
        aux_en    = 1'b0;
        aux_digit = 4'd2;
        watch(40, "aux_off");
    endtask

    task automatic test_blink;
        aux_en    = 1'b1;
        aux_digit = 4'd5;
        blink_en  = 1'b1;
        watch(300, "blink");
        blink_en = 1'b0;
        watch(70, "unblink");
    endtask

    task automatic test_random;
        for (int i = 0; i < 10; i++) begin
            aux_en    = 1'($urandom_range(0, 1));
            aux_digit = 4'($urandom_range(0, 15));
            blink_en  = ($urandom_range(0, 3) == 0);
            convert(int'($urandom_range(0, 1023)), int'($urandom_range(0, 10)),
                    int'($urandom_range(0, 1023)), "rnd");
            watch(int'($urandom_range(20, 90)), "rnd");
        end
        blink_en = 1'b0;
    endtask

    initial begin
        test_reset;
        test_load_125;
        test_load_7;
        test_overflow;
        test_aux;
        test_blink;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
